// File: rtl/mux_rr_nto1.sv
// N-to-1 registered multiplexer with per-channel valid/ready and a one-entry output buffer.
// Selection is either an explicit channel select (MODE=0) or round-robin among valid channels (MODE=1).
module mux_rr_nto1 #(
    parameter int WIDTH = 48,
    parameter int N     = 4,
    parameter int SW    = $clog2(N),
    parameter int MODE  = 0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] Hyrja,
    input  logic [N-1:0]       HyrjaValid,
    output logic [N-1:0]       HyrjaReady,
    input  logic [SW-1:0]      S,
    output logic [WIDTH-1:0]   Dalja,
    output logic               DaljaValid,
    input  logic               DaljaReady,
    output logic [SW-1:0]      DaljaKanali
);

    logic [SW-1:0]    ptr_p1;
    logic             accept_p0;
    logic             xfer_p0;
    logic             grant_vld_p0;
    logic [SW-1:0]    grant_p0;
    logic [WIDTH-1:0] data_sel_p0;

    logic             hi_vld_p0;
    logic [SW-1:0]    hi_idx_p0;
    logic             lo_vld_p0;
    logic [SW-1:0]    lo_idx_p0;

    // Stage p0: buffer availability, grant selection and handshake
    assign accept_p0 = !DaljaValid || DaljaReady;

    // Round-robin search: lowest valid channel at or above ptr, else lowest valid overall.
    always_comb begin
        hi_vld_p0 = 1'b0;
        hi_idx_p0 = '0;
        lo_vld_p0 = 1'b0;
        lo_idx_p0 = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (HyrjaValid[i]) begin
                lo_vld_p0 = 1'b1;
                lo_idx_p0 = SW'(i);
                if (SW'(i) >= ptr_p1) begin
                    hi_vld_p0 = 1'b1;
                    hi_idx_p0 = SW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_vld_p0 = 1'b0;
        grant_p0     = '0;
        if (MODE == 0) begin
            // S values at or beyond N match no channel and therefore never grant.
            for (int i = 0; i < N; i++) begin
                if (S == SW'(i) && HyrjaValid[i]) begin
                    grant_vld_p0 = 1'b1;
                    grant_p0     = SW'(i);
                end
            end
        end else if (hi_vld_p0) begin
            grant_vld_p0 = 1'b1;
            grant_p0     = hi_idx_p0;
        end else if (lo_vld_p0) begin
            grant_vld_p0 = 1'b1;
            grant_p0     = lo_idx_p0;
        end
    end

    always_comb begin
        data_sel_p0 = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_p0 == SW'(i)) begin
                data_sel_p0 = Hyrja[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer_p0 = accept_p0 && grant_vld_p0;

    always_comb begin
        HyrjaReady = '0;
        for (int i = 0; i < N; i++) begin
            HyrjaReady[i] = !Reset && xfer_p0 && (grant_p0 == SW'(i));
        end
    end

    // Stage p1: output buffer and round-robin pointer
    always_ff @(posedge Clock) begin
        if (Reset) begin
            DaljaValid  <= 1'b0;
            Dalja       <= '0;
            DaljaKanali <= '0;
            ptr_p1      <= '0;
        end else if (xfer_p0) begin
            DaljaValid  <= 1'b1;
            Dalja       <= data_sel_p0;
            DaljaKanali <= grant_p0;
            if (MODE == 1) begin
                ptr_p1 <= (int'(grant_p0) == N - 1) ? '0 : grant_p0 + SW'(1);
            end
        end else if (DaljaReady) begin
            DaljaValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Directed bench for mux_rr_nto1: a round-robin N=4 instance and an explicit-select N=3 instance.
module tb_mux_rr_nto1;

    logic clk = 1'b0;
    logic rst;

    logic [4*48-1:0] h1;
    logic [3:0]      v1;
    logic [3:0]      r1;
    logic [1:0]      s1;
    logic [47:0]     d1;
    logic            dv1;
    logic            dr1;
    logic [1:0]      k1;

    logic [3*48-1:0] h0;
    logic [2:0]      v0;
    logic [2:0]      r0;
    logic [1:0]      s0;
    logic [47:0]     d0;
    logic            dv0;
    logic            dr0;
    logic [1:0]      k0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_rr_nto1 #(.WIDTH(48), .N(4), .MODE(1)) dut_rr (
        .Clock(clk), .Reset(rst), .Hyrja(h1), .HyrjaValid(v1), .HyrjaReady(r1), .S(s1),
        .Dalja(d1), .DaljaValid(dv1), .DaljaReady(dr1), .DaljaKanali(k1)
    );

    mux_rr_nto1 #(.WIDTH(48), .N(3), .MODE(0)) dut_sel (
        .Clock(clk), .Reset(rst), .Hyrja(h0), .HyrjaValid(v0), .HyrjaReady(r0), .S(s0),
        .Dalja(d0), .DaljaValid(dv0), .DaljaReady(dr0), .DaljaKanali(k0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] g;
        rst = 1'b1;
        v1  = 4'b1111;
        dr1 = 1'b1;
        s1  = 2'd0;
        for (int i = 0; i < 4; i++) h1[i*48 +: 48] = 48'h100 + 48'(i);
        v0  = 3'b000;
        dr0 = 1'b1;
        s0  = 2'd0;
        for (int i = 0; i < 3; i++) h0[i*48 +: 48] = 48'h200 + 48'(i);

        // reset held two cycles with every channel valid
        #1;
        chk("rst_ready_c0", 64'(r1), 64'h0);
        step();
        chk("rst_valid_c1", 64'(dv1), 64'h0);
        chk("rst_data_c1", 64'(d1), 64'h0);
        chk("rst_ready_c1", 64'(r1), 64'h0);
        chk("rst_sel_valid", 64'(dv0), 64'h0);
        step();
        chk("rst_valid_c2", 64'(dv1), 64'h0);
        chk("rst_kanali_c2", 64'(k1), 64'h0);
        chk("rst_ready_c2", 64'(r1), 64'h0);
        rst = 1'b0;
        #1;
        chk("first_grant", 64'(r1), 64'h1);

        // round-robin sweep, one word per cycle
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_kanali", 64'(k1), 64'(i % 4));
            chk("rr_data", 64'(d1), 64'h100 + 64'(i % 4));
            chk("rr_valid", 64'(dv1), 64'h1);
            chk("rr_ready", 64'(r1), 64'(4'b0001 << ((i + 1) % 4)));
        end

        // idle channels 0 and 2 are skipped
        v1 = 4'b1010;
        #1;
        chk("skip_ready0", 64'(r1), 64'h2);
        for (int j = 0; j < 4; j++) begin
            g = (j % 2 == 0) ? 2'd1 : 2'd3;
            step();
            chk("skip_kanali", 64'(k1), 64'(g));
            chk("skip_ready", 64'(r1), (g == 2'd1) ? 64'h8 : 64'h2);
        end

        // backpressure holds the buffered word
        v1 = 4'b0001;
        h1[0 +: 48] = 48'hABCDEF012345;
        #1;
        chk("bp_ready_load", 64'(r1), 64'h1);
        step();
        chk("bp_loaded", 64'(d1), 64'hABCDEF012345);
        dr1 = 1'b0;
        h1[0 +: 48] = 48'h111111111111;
        #1;
        for (int j = 0; j < 5; j++) begin
            chk("bp_ready_hold", 64'(r1), 64'h0);
            chk("bp_data_hold", 64'(d1), 64'hABCDEF012345);
            chk("bp_valid_hold", 64'(dv1), 64'h1);
            step();
        end
        dr1 = 1'b1;
        #1;
        chk("bp_release_ready", 64'(r1), 64'h1);
        step();
        chk("bp_next_data", 64'(d1), 64'h111111111111);
        chk("bp_next_kanali", 64'(k1), 64'h0);

        // mid-stream reset with a held word and ptr=2
        v1 = 4'b0010;
        #1;
        chk("mr_ready_ch1", 64'(r1), 64'h2);
        step();
        chk("mr_kanali1", 64'(k1), 64'h1);
        chk("mr_data1", 64'(d1), 64'h101);
        dr1 = 1'b0;
        v1  = 4'b1111;
        #1;
        chk("mr_ready_stall", 64'(r1), 64'h0);
        rst = 1'b1;
        #1;
        chk("mr_ready_in_rst", 64'(r1), 64'h0);
        step();
        chk("mr_valid_cleared", 64'(dv1), 64'h0);
        chk("mr_data_cleared", 64'(d1), 64'h0);
        chk("mr_kanali_cleared", 64'(k1), 64'h0);
        rst = 1'b0;
        dr1 = 1'b1;
        #1;
        chk("mr_grant_from0", 64'(r1), 64'h1);
        step();
        chk("mr_kanali0", 64'(k1), 64'h0);
        chk("mr_data0", 64'(d1), 64'h111111111111);

        // explicit select, N=3
        v0 = 3'b111;
        s0 = 2'd2;
        #1;
        chk("sel2_ready", 64'(r0), 64'h4);
        step();
        chk("sel2_data", 64'(d0), 64'h202);
        chk("sel2_kanali", 64'(k0), 64'h2);
        chk("sel2_valid", 64'(dv0), 64'h1);
        chk("sel2_ready_again", 64'(r0), 64'h4);
        step();
        chk("sel2_kanali_again", 64'(k0), 64'h2);
        s0 = 2'd3;
        #1;
        chk("sel3_no_ready", 64'(r0), 64'h0);
        step();
        chk("sel3_drained", 64'(dv0), 64'h0);
        s0 = 2'd1;
        v0 = 3'b101;
        #1;
        chk("sel1_invalid", 64'(r0), 64'h0);
        s0 = 2'd2;
        v0 = 3'b111;
        #1;
        chk("sel2_back", 64'(r0), 64'h4);
        step();
        chk("sel2_reload", 64'(d0), 64'h202);
        dr0 = 1'b0;
        s0  = 2'd0;
        #1;
        chk("sel0_stalled", 64'(r0), 64'h0);
        step();
        chk("sel0_hold_data", 64'(d0), 64'h202);
        chk("sel0_hold_kanali", 64'(k0), 64'h2);
        chk("sel0_hold_valid", 64'(dv0), 64'h1);
        dr0 = 1'b1;
        #1;
        chk("sel0_ready", 64'(r0), 64'h1);
        step();
        chk("sel0_data", 64'(d0), 64'h200);
        chk("sel0_kanali", 64'(k0), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_nto1.md
# mux_rr_nto1

Parametrised N-to-1 registered multiplexer with valid/ready handshaking on every channel and a one-entry output buffer. It replaces the fixed 48-bit 2:1 select wherever several producers share one consumer, such as result buses and memory request paths in the 24-bit CPU. It supports two modes: an explicit select input, and round-robin arbitration among valid channels.

## Interface
- WIDTH, 48, data width per channel.
- N, 4, number of input channels (N >= 2).
- SW, $clog2(N), width of select and channel-index fields.
- MODE, 0, selection mode: 0 = explicit select via S; 1 = round-robin arbitration.

- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Hyrja  input  N*WIDTH  channel data, flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- HyrjaValid  input  N  per-channel valid.
- HyrjaReady  output  N  per-channel ready; combinational.
- S  input  SW  channel select; used only when MODE=0.
- Dalja  output  WIDTH  registered output data.
- DaljaValid  output  1  output buffer holds a word.
- DaljaReady  input  1  consumer accepts this cycle.
- DaljaKanali  output  SW  index of the channel that produced the current Dalja word.

## Operation
- Transfer definitions:
  - An input transfer on channel i occurs when HyrjaValid[i] && HyrjaReady[i].
  - An output transfer occurs when DaljaValid && DaljaReady.
- Output buffer:
  - The buffer has one entry.
  - accept = !DaljaValid || DaljaReady, so an output transfer frees the buffer for a same-cycle input transfer.
- Grant, computed combinationally each cycle:
  - MODE=0: grant = S when HyrjaValid[S] is high and S < N. Otherwise there is no grant, including when S >= N (possible for non-power-of-2 N).
  - MODE=1: the grant goes to the first valid channel searching from the pointer ptr upward, i.e. ptr, ptr+1, ..., N-1, 0, ..., ptr-1. There is no grant if no channel is valid.
- HyrjaReady[i] = accept && grant exists && grant == i. At most one bit is high per cycle. No channel sees ready without a grant.
- On an input transfer from channel g:
  - Dalja <= channel g data.
  - DaljaKanali <= g.
  - DaljaValid <= 1.
- On an output transfer with no input transfer: DaljaValid <= 0. Dalja and DaljaKanali keep their last values.
- While DaljaValid && !DaljaReady, Dalja and DaljaKanali are held stable, and no HyrjaReady bit is asserted.
- Round-robin pointer (MODE=1 only):
  - On an input transfer from g, ptr <= (g == N-1) ? 0 : g+1.
  - ptr is unchanged when no input transfer occurs.
  - MODE=0 ignores ptr, which stays at 0.
- No data is dropped or duplicated. Each input transfer produces exactly one output transfer, in acceptance order.
- Reset, which takes priority over all other activity:
  - DaljaValid=0, Dalja=0, DaljaKanali=0, ptr=0.
  - HyrjaReady is 0 during the reset cycle.
  - A word held in the buffer when Reset is asserted mid-stream is discarded.

## Timing
- Latency: an input transfer at edge k makes DaljaValid=1 and the new Dalja visible after edge k.
- Throughput: with DaljaReady held high, the block sustains one word per cycle.
- Round-robin fairness: with all N channels continuously valid, each channel is granted exactly once in every N consecutive transfers.
- HyrjaReady depends combinationally on HyrjaValid, S, DaljaValid, DaljaReady and ptr. The outputs Dalja, DaljaValid and DaljaKanali are registered only.
- The first cycle after Reset deasserts may accept an input.

## Test plan
- Reset check, MODE=1, N=4: assert Reset for 2 cycles with all HyrjaValid=4'b1111. Required: DaljaValid=0, Dalja=0 and HyrjaReady=0 during reset. The first grant after reset goes to channel 0.
- Round-robin sweep, MODE=1, N=4: all valid continuously, DaljaReady=1, channel i data = 48'h100+i. Required: DaljaKanali sequence 0,1,2,3,0,1,… with one word per cycle, Dalja matching the channel data.
- Skip of idle channels, MODE=1: HyrjaValid=4'b1010 held. Required: grants alternate 1,3,1,3, and channels 0 and 2 never see ready.
- Backpressure: DaljaReady=0 for 5 cycles after the first word 48'hABCDEF012345 is loaded. Required:
  - Dalja stays at 48'hABCDEF012345 and DaljaValid stays 1.
  - HyrjaReady=0 throughout.
  - When DaljaReady rises, the next word loads in that same cycle.
- Explicit select, MODE=0, N=3: S=2 with HyrjaValid=3'b111 gives grants only to channel 2. S=3 gives no grant and DaljaValid falls after drain. Changing S to 0 mid-stream takes effect on the next accept.
- Mid-stream reset: assert Reset while DaljaValid=1, DaljaReady=0 and ptr=2. Required: the next cycle shows DaljaValid=0, and the next grant starts from channel 0.
